// File: rtl/conv_kxk_stream_engine.sv
// KxK strided convolution over one feature-map strip. Each window is reduced by a
// single sequential MAC fed from a 1-cycle-latency BRAM; results leave on a stream.
module conv_kxk_stream_engine #(
  parameter int DATA_W  = 9,
  parameter int COEF_W  = 9,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int IMG_W   = 224,
  parameter int IMG_H   = 30,
  parameter int K       = 3,
  parameter int STRIDE  = 1,
  parameter int RELU_EN = 0,
  parameter int ADDR_W  = 16,
  localparam int KI_W   = (K * K > 1) ? $clog2(K * K) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     k_we,
  input  logic [KI_W-1:0]          k_idx,
  input  logic signed [COEF_W-1:0] k_data,
  output logic                     fm_rd_en,
  output logic [ADDR_W-1:0]        fm_addr,
  input  logic signed [DATA_W-1:0] fm_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [ADDR_W-1:0]        out_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int TAPS = K * K;
  localparam int OW   = (IMG_W - K) / STRIDE + 1;
  localparam int OH   = (IMG_H - K) / STRIDE + 1;
  localparam int KC_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [KC_W-1:0]   K_LAST  = KC_W'(K - 1);
  localparam logic [ADDR_W-1:0] OX_LAST = ADDR_W'(OW - 1);
  localparam logic [ADDR_W-1:0] OY_LAST = ADDR_W'(OH - 1);
  localparam longint SAT_MAX = (longint'(1) <<< (OUT_W - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) <<< (OUT_W - 1));

  if (longint'(OW) * longint'(OH) > (longint'(1) <<< ADDR_W) ||
      longint'(IMG_W) * longint'(IMG_H) > (longint'(1) <<< ADDR_W)) begin : g_addr_chk
    $error("conv_kxk_stream_engine: ADDR_W too small for the strip or output grid");
  end
  if (K < 1 || K > IMG_W || K > IMG_H || STRIDE < 1) begin : g_geom_chk
    $error("conv_kxk_stream_engine: illegal kernel/stride geometry");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_FLUSH, S_EMIT, S_DONE} state_t;

  state_t                      state, state_nx;
  logic signed [COEF_W-1:0]    coef [TAPS];
  logic signed [ACC_W-1:0]     acc;
  logic [KC_W-1:0]             kx, ky;
  logic [ADDR_W-1:0]           ox, oy;
  logic [KI_W-1:0]             tap, tap_d;
  logic                        mac_en;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]     prod_ext;
  logic [31:0]                 addr_full;
  logic                        last_tap, last_win;
  longint                      acc_l;
  logic [OUT_W-1:0]            sat_val;

  assign tap       = KI_W'(32'(ky) * 32'(K) + 32'(kx));
  assign addr_full = (32'(oy) * 32'(STRIDE) + 32'(ky)) * 32'(IMG_W) + 32'(ox) * 32'(STRIDE) + 32'(kx);
  assign last_tap  = (kx == K_LAST) && (ky == K_LAST);
  assign last_win  = (ox == OX_LAST) && (oy == OY_LAST);
  // The read data arriving now belongs to the tap issued one cycle ago.
  assign prod      = fm_data * coef[tap_d];
  assign prod_ext  = ACC_W'(prod);
  assign out_idx   = ADDR_W'(32'(oy) * 32'(OW) + 32'(ox));

  always_comb begin
    acc_l = longint'(acc);
    if (RELU_EN != 0 && acc_l < 0) acc_l = 0;
    if (acc_l > SAT_MAX)      acc_l = SAT_MAX;
    else if (acc_l < SAT_MIN) acc_l = SAT_MIN;
    sat_val = OUT_W'(acc_l);
  end

  // Stream: a result transfers on any clock edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, out_data/out_idx do not change.
  always_comb begin
    state_nx  = state;
    fm_rd_en  = 1'b0;
    fm_addr   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_CLEAR;
      S_CLEAR: state_nx = S_ISSUE;
      S_ISSUE: begin
        fm_rd_en = 1'b1;
        fm_addr  = ADDR_W'(addr_full);
        if (last_tap) state_nx = S_FLUSH;
      end
      S_FLUSH: state_nx = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        out_data  = sat_val;
        if (out_ready) state_nx = last_win ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      kx     <= '0;
      ky     <= '0;
      ox     <= '0;
      oy     <= '0;
      tap_d  <= '0;
      mac_en <= 1'b0;
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else begin
      state  <= state_nx;
      mac_en <= fm_rd_en;
      tap_d  <= tap;
      if (state == S_IDLE && k_we && 32'(k_idx) < 32'(TAPS)) coef[k_idx] <= k_data;
      if (state == S_CLEAR)  acc <= '0;
      else if (mac_en)       acc <= acc + prod_ext;
      case (state)
        S_IDLE: begin
          ox <= '0;
          oy <= '0;
        end
        S_CLEAR: begin
          kx <= '0;
          ky <= '0;
        end
        S_ISSUE: begin
          if (kx == K_LAST) begin
            kx <= '0;
            ky <= ky + 1'b1;
          end else begin
            kx <= kx + 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready && !last_win) begin
            if (ox == OX_LAST) begin
              ox <= '0;
              oy <= oy + 1'b1;
            end else begin
              ox <= ox + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_kxk_stream_engine.sv
// Directed bench for conv_kxk_stream_engine: two geometries (5x4 stride 1, 7x5 stride 2
// with ReLU), BRAM models, expected-value queues and one summary line.
module tb_conv_kxk_stream_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               a_start, a_k_we, b_start, b_k_we;
  logic [3:0]         k_idx;
  logic [8:0]         k_data;
  logic               out_ready;
  logic               a_fm_rd_en, b_fm_rd_en;
  logic [15:0]        a_fm_addr, b_fm_addr;
  logic signed [8:0]  a_fm_data, b_fm_data;
  logic               a_out_valid, b_out_valid;
  logic [15:0]        a_out_data, b_out_data, a_out_idx, b_out_idx;
  logic               a_busy, b_busy, a_done, b_done;

  conv_kxk_stream_engine #(
    .DATA_W(9), .COEF_W(9), .ACC_W(32), .OUT_W(16), .IMG_W(5), .IMG_H(4),
    .K(3), .STRIDE(1), .RELU_EN(0), .ADDR_W(16)
  ) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .k_we(a_k_we), .k_idx(k_idx),
    .k_data(k_data), .fm_rd_en(a_fm_rd_en), .fm_addr(a_fm_addr), .fm_data(a_fm_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_idx(a_out_idx), .busy(a_busy), .done(a_done)
  );

  conv_kxk_stream_engine #(
    .DATA_W(9), .COEF_W(9), .ACC_W(32), .OUT_W(16), .IMG_W(7), .IMG_H(5),
    .K(3), .STRIDE(2), .RELU_EN(1), .ADDR_W(16)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .k_we(b_k_we), .k_idx(k_idx),
    .k_data(k_data), .fm_rd_en(b_fm_rd_en), .fm_addr(b_fm_addr), .fm_data(b_fm_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .busy(b_busy), .done(b_done)
  );

  // BRAM models: pixel = address, or constant 255
  bit pix_mode;
  function automatic logic [8:0] pix(input logic [15:0] a);
    return pix_mode ? 9'd255 : a[8:0];
  endfunction
  always @(posedge clk) if (a_fm_rd_en) a_fm_data <= pix(a_fm_addr);
  always @(posedge clk) if (b_fm_rd_en) b_fm_data <= pix(b_fm_addr);

  bit          sel_b;
  logic        m_fm_rd_en, m_out_valid, m_busy, m_done;
  logic [15:0] m_fm_addr, m_out_data, m_out_idx;
  assign m_fm_rd_en  = sel_b ? b_fm_rd_en  : a_fm_rd_en;
  assign m_fm_addr   = sel_b ? b_fm_addr   : a_fm_addr;
  assign m_out_valid = sel_b ? b_out_valid : a_out_valid;
  assign m_out_data  = sel_b ? b_out_data  : a_out_data;
  assign m_out_idx   = sel_b ? b_out_idx   : a_out_idx;
  assign m_busy      = sel_b ? b_busy      : a_busy;
  assign m_done      = sel_b ? b_done      : a_done;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_idx_q[$];
  logic [15:0] addr_q[$];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input bit sel, input int idx, input int val);
    @(negedge clk);
    k_idx  = 4'(idx);
    k_data = 9'(val);
    if (sel) b_k_we = 1'b1; else a_k_we = 1'b1;
    @(negedge clk);
    a_k_we = 1'b0;
    b_k_we = 1'b0;
  endtask

  task automatic set_all(input bit sel, input int val);
    for (int i = 0; i < 9; i++) load(sel, i, val);
  endtask

  task automatic set_one(input bit sel, input int idx, input int val);
    set_all(sel, 0);
    load(sel, idx, val);
  endtask

  // 3x2 output grid, expected value = base + ox*sx + oy*sy
  task automatic push_grid(input int base, input int sx, input int sy);
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 3; ox++) begin
        exp_q.push_back(16'(base + ox * sx + oy * sy));
        exp_idx_q.push_back(16'(oy * 3 + ox));
      end
  endtask

  task automatic run_job(input bit sel, input int stall_res, input int stall_len,
                         input bit kpulse, input string tag);
    int cyc, n_res, done_cnt, prev_acc, stall_cnt, done_cyc;
    bit stalled;
    logic [15:0] held_d, held_i, ed, ei;
    cyc = 0; n_res = 0; done_cnt = 0; prev_acc = 0; stall_cnt = 0; done_cyc = -1;
    stalled = 1'b0; held_d = '0; held_i = '0;
    sel_b = sel;
    out_ready = 1'b1;
    addr_q.delete();
    @(negedge clk);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
    cyc = 1;
    while (done_cnt == 0 && cyc < 1000) begin
      if (kpulse) begin
        if (cyc == 5) begin
          k_idx = 4'd0; k_data = 9'd5;
          if (sel) b_k_we = 1'b1; else a_k_we = 1'b1;
        end else begin
          a_k_we = 1'b0; b_k_we = 1'b0;
        end
      end
      if (m_fm_rd_en && addr_q.size() < 9) addr_q.push_back(m_fm_addr);
      if (m_done) begin done_cnt++; done_cyc = cyc; end
      if (m_out_valid) begin
        if (n_res == stall_res && stall_cnt < stall_len) begin
          out_ready = 1'b0;
          if (stall_cnt == 0) begin
            held_d = m_out_data; held_i = m_out_idx;
          end else begin
            check({tag, "_stall_data"}, $signed(m_out_data), $signed(held_d));
            check({tag, "_stall_idx"}, m_out_idx, held_i);
          end
          check({tag, "_stall_rd_en"}, m_fm_rd_en, 0);
          stall_cnt++;
          stalled = 1'b1;
        end else begin
          out_ready = 1'b1;
          if (exp_q.size() == 0) begin
            check({tag, "_extra_result"}, n_res, 6);
          end else begin
            ed = exp_q.pop_front();
            ei = exp_idx_q.pop_front();
            check($sformatf("%s_data%0d", tag, n_res), $signed(m_out_data), $signed(ed));
            check($sformatf("%s_idx%0d", tag, n_res), m_out_idx, ei);
          end
          if (!stalled) check($sformatf("%s_lat%0d", tag, n_res), cyc - prev_acc, 12);
          stalled = 1'b0;
          prev_acc = cyc;
          n_res++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    check({tag, "_n_results"}, n_res, 6);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_done_after_last"}, done_cyc, prev_acc + 1);
    check({tag, "_idle_after"}, {m_busy, m_done}, 0);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    if (stall_res >= 0) check({tag, "_stall_len"}, stall_cnt, stall_len);
  endtask

  int dcnt;

  initial begin
    reset = 1'b1;
    a_start = 1'b0; b_start = 1'b0; a_k_we = 1'b0; b_k_we = 1'b0;
    k_idx = '0; k_data = '0; out_ready = 1'b1; pix_mode = 1'b0; sel_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_flags", {a_fm_rd_en, a_out_valid, a_busy, a_done}, 0);
    check("rst_a_addr", a_fm_addr, 0);
    check("rst_a_data", a_out_data, 0);
    check("rst_a_idx", a_out_idx, 0);
    check("rst_b_flags", {b_fm_rd_en, b_out_valid, b_busy, b_done}, 0);
    reset = 1'b0;

    // all-ones kernel, pixel = address; out-of-range index must be ignored
    set_all(0, 1);
    load(0, 9, 100);
    load(0, 15, 100);
    push_grid(54, 9, 45);
    run_job(0, -1, 0, 0, "ones");

    // centre tap only; a k_we pulse during the run must not disturb results
    set_one(0, 4, 1);
    push_grid(6, 1, 5);
    run_job(0, -1, 0, 1, "centre");
    check("addr_count", addr_q.size(), 9);
    for (int i = 0; i < 9 && i < addr_q.size(); i++)
      check($sformatf("win0_addr%0d", i), addr_q[i], (i / 3) * 5 + (i % 3));

    // backpressure on result 2
    set_all(0, 1);
    push_grid(54, 9, 45);
    run_job(0, 2, 10, 0, "stall");

    // stride 2 on the 7x5 strip, top-left tap only
    set_one(1, 0, 1);
    push_grid(0, 2, 14);
    run_job(1, -1, 0, 0, "stride2");

    // ReLU clamps the negative sums
    pix_mode = 1'b1;
    set_all(1, -1);
    push_grid(0, 0, 0);
    run_job(1, -1, 0, 0, "relu");

    // positive and negative saturation
    set_all(0, 255);
    push_grid(32767, 0, 0);
    run_job(0, -1, 0, 0, "sat_pos");
    set_all(0, -255);
    push_grid(-32768, 0, 0);
    run_job(0, -1, 0, 0, "sat_neg");

    // reset during ISSUE of result 2 (third result)
    pix_mode = 1'b0;
    set_all(0, 1);
    sel_b = 1'b0;
    dcnt = 0;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    repeat (27) begin
      @(negedge clk);
      if (a_done) dcnt++;
    end
    check("mid_in_issue", {a_fm_rd_en, a_busy}, 3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_flags", {a_fm_rd_en, a_out_valid, a_busy, a_done}, 0);
    check("mid_rst_addr", a_fm_addr, 0);
    check("mid_rst_data", a_out_data, 0);
    check("mid_rst_idx", a_out_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (a_done) dcnt++;
    end
    check("mid_no_done", dcnt, 0);
    check("mid_idle", a_busy, 0);

    // coefficients were cleared by reset
    push_grid(0, 0, 0);
    run_job(0, -1, 0, 0, "cleared");

    // reload and rerun from out_idx 0
    set_all(0, 1);
    push_grid(54, 9, 45);
    run_job(0, -1, 0, 0, "rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
